idex_pipeline_reg: RTL and testbench
====================================

// Module: idex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core. Captures decoded operands, register
//  specifiers and control bits from ID each cycle. Consumes the hazard unit's Stall to insert
//  a bubble (zeroed control). Feeds IDEXMemRead/IDEXRegRt back to hazard detection and
//  forwarding. Keeps saturating bubble and flush counters for performance debug.
// PARAMETERS
//  DW   32  width of PC+4, operand and immediate fields
//  CW   16  width of the BubbleCount and FlushCount performance counters
// PORTS
//  clk            in   1   pipeline clock; all state updates on posedge
//  rst_n          in   1   synchronous, active-low reset
//  Hold           in   1   global freeze: no register updates
//  Flush          in   1   branch/jump squash: load a bubble
//  Stall          in   1   load-use stall from hazard detection: load a bubble
//  IDPC4          in   DW  PC+4 of the instruction in ID
//  IDReadData1    in   DW  register-file port 1 data
//  IDReadData2    in   DW  register-file port 2 data
//  IDSignExtImm   in   DW  sign-extended immediate
//  IDRegRs/Rt/Rd  in   5   register specifiers
//  IDRegWrite, IDMemtoReg, IDMemRead, IDMemWrite, IDBranch, IDRegDst, IDALUSrc  in 1 each
//  IDALUOp        in   2   ALU control class
//  IDEX*          out  -   registered copy of every ID* input above, same width
//  IDEXValid      out  1   1 = real instruction in EX; 0 = bubble or reset
//  BubbleCount    out  CW  bubbles inserted by Stall, saturating
//  FlushCount     out  CW  bubbles inserted by Flush, saturating
// BEHAVIOUR
//  - Resolution on each posedge, highest priority first: reset > Hold > Flush > Stall > load.
//  - Reset: rst_n=0 at a posedge. All outputs go to 0, counters included. This includes
//    mid-stall or mid-flush.
//  - Hold=1: every register keeps its value, counters included. A Flush or Stall seen
//    during Hold is ignored. The source must keep it asserted until Hold drops.
//  - Load (Hold=0, Flush=0, Stall=0): every IDEX* <= ID*, and IDEXValid <= 1.
//  - Bubble (Flush=1 or Stall=1):
//    - Clear these outputs to 0: IDEXRegWrite, IDEXMemtoReg, IDEXMemRead, IDEXMemWrite,
//      IDEXBranch, IDEXRegDst, IDEXALUSrc, IDEXALUOp, IDEXValid.
//    - The data fields and IDEXRegRs/Rt/Rd still load from ID. Downstream ignores them
//      because the control bits are 0.
//  - Counters: increment FlushCount when Flush wins, or BubbleCount when Stall wins.
//    - If Flush and Stall are both set, only FlushCount increments.
//    - Each counter saturates at 2^CW-1 and never wraps.
//  - Latency: 1 cycle from ID* to IDEX*. No combinational path from input to output.
//  - Stall release: a bubble clears IDEXMemRead. The hazard unit therefore deasserts Stall
//    on the following cycle, which bounds a load-use stall to exactly 1 cycle.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with random ID* inputs -> all outputs and both counters 0,
//    IDEXValid=0.
//  2 Load-use: lw $8 in EX (IDEXMemRead=1, IDEXRegRt=8), ID has add $9,$8,$1, so Stall=1
//    -> next cycle IDEXMemRead=0, IDEXRegWrite=0, IDEXValid=0, BubbleCount=1. The cycle
//    after that, Stall=0 and the add loads with IDEXValid=1.
//  3 Flush and Stall together in one cycle -> bubble loaded, FlushCount=1, BubbleCount
//    unchanged.
//  4 Hold=1 for 3 cycles with Stall=1 and changing ID* -> all IDEX* and both counters frozen.
//    Hold=0 with Stall still 1 -> one bubble, BubbleCount+1.
//  5 CW=4, 20 consecutive Stall cycles -> BubbleCount sticks at 15 and does not wrap.
//  6 Reset mid-stream: rst_n=0 during the cycle in which Flush=1 and FlushCount=7 ->
//    FlushCount=0 and all IDEX*=0. The first load after rst_n=1 sets IDEXValid=1.

Source files
------------

// File: rtl/idex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded operands and control from ID.
// Stall/Flush load a bubble (control zeroed); saturating counters track bubble sources.
module idex_pipeline_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_hold,
    input  logic          i_flush,
    input  logic          i_stall,
    input  logic [DW-1:0] i_id_pc4,
    input  logic [DW-1:0] i_id_read_data1,
    input  logic [DW-1:0] i_id_read_data2,
    input  logic [DW-1:0] i_id_sign_ext_imm,
    input  logic [4:0]    i_id_reg_rs,
    input  logic [4:0]    i_id_reg_rt,
    input  logic [4:0]    i_id_reg_rd,
    input  logic          i_id_reg_write,
    input  logic          i_id_memto_reg,
    input  logic          i_id_mem_read,
    input  logic          i_id_mem_write,
    input  logic          i_id_branch,
    input  logic          i_id_reg_dst,
    input  logic          i_id_alu_src,
    input  logic [1:0]    i_id_alu_op,
    output logic [DW-1:0] o_idex_pc4,
    output logic [DW-1:0] o_idex_read_data1,
    output logic [DW-1:0] o_idex_read_data2,
    output logic [DW-1:0] o_idex_sign_ext_imm,
    output logic [4:0]    o_idex_reg_rs,
    output logic [4:0]    o_idex_reg_rt,
    output logic [4:0]    o_idex_reg_rd,
    output logic          o_idex_reg_write,
    output logic          o_idex_memto_reg,
    output logic          o_idex_mem_read,
    output logic          o_idex_mem_write,
    output logic          o_idex_branch,
    output logic          o_idex_reg_dst,
    output logic          o_idex_alu_src,
    output logic [1:0]    o_idex_alu_op,
    output logic          o_idex_valid,
    output logic [CW-1:0] o_bubble_count,
    output logic [CW-1:0] o_flush_count
);

    logic [DW-1:0] r_pc4;
    logic [DW-1:0] r_rd1;
    logic [DW-1:0] r_rd2;
    logic [DW-1:0] r_imm;
    logic [4:0]    r_rs;
    logic [4:0]    r_rt;
    logic [4:0]    r_rd;
    logic [8:0]    r_ctrl;
    logic          r_valid;
    logic [CW-1:0] r_bubble_cnt;
    logic [CW-1:0] r_flush_cnt;

    logic [8:0]    w_ctrl;
    logic          w_bubble;

    assign w_ctrl   = {i_id_reg_write, i_id_memto_reg, i_id_mem_read, i_id_mem_write,
                       i_id_branch, i_id_reg_dst, i_id_alu_src, i_id_alu_op};
    assign w_bubble = i_flush | i_stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc4        <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_ctrl       <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else if (!i_hold) begin
            // Data and specifiers load even on a bubble; zeroed control makes them inert.
            r_pc4 <= i_id_pc4;
            r_rd1 <= i_id_read_data1;
            r_rd2 <= i_id_read_data2;
            r_imm <= i_id_sign_ext_imm;
            r_rs  <= i_id_reg_rs;
            r_rt  <= i_id_reg_rt;
            r_rd  <= i_id_reg_rd;
            if (w_bubble) begin
                r_ctrl  <= '0;
                r_valid <= 1'b0;
            end else begin
                r_ctrl  <= w_ctrl;
                r_valid <= 1'b1;
            end
            if (i_flush) begin
                if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
            end else if (i_stall) begin
                if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign o_idex_pc4          = r_pc4;
    assign o_idex_read_data1   = r_rd1;
    assign o_idex_read_data2   = r_rd2;
    assign o_idex_sign_ext_imm = r_imm;
    assign o_idex_reg_rs       = r_rs;
    assign o_idex_reg_rt       = r_rt;
    assign o_idex_reg_rd       = r_rd;
    assign {o_idex_reg_write, o_idex_memto_reg, o_idex_mem_read, o_idex_mem_write,
            o_idex_branch, o_idex_reg_dst, o_idex_alu_src, o_idex_alu_op} = r_ctrl;
    assign o_idex_valid        = r_valid;
    assign o_bubble_count      = r_bubble_cnt;
    assign o_flush_count       = r_flush_cnt;

endmodule

// File: tb/tb_idex_pipeline_reg.sv
// Scoreboard bench for idex_pipeline_reg: driver queues hand-computed expectations,
// monitor pops one per clock and compares against the registered outputs.
module tb_idex_pipeline_reg;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [8:0]  ctrl;  // {rw, m2r, mr, mw, br, rdst, asrc, aluop[1:0]}
    } id_t;

    typedef struct packed {
        id_t        f;
        logic       valid;
        logic [3:0] bc;
        logic [3:0] fc;
    } out_t;

    typedef enum int {KZero, KLoad, KBubble, KHold} kind_e;

    logic clk = 1'b0;
    logic rst_n, hold, flush, stall;
    id_t  id;
    out_t act;

    logic [31:0] o_pc4, o_rd1, o_rd2, o_imm;
    logic [4:0]  o_rs, o_rt, o_rd;
    logic        o_rw, o_m2r, o_mr, o_mw, o_br, o_rdst, o_asrc, o_valid;
    logic [1:0]  o_aluop;
    logic [3:0]  o_bc, o_fc;

    out_t q_exp[$];
    int   q_tag[$];
    out_t last_exp;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   tag    = 0;

    always #5 clk = ~clk;

    idex_pipeline_reg #(.DW(32), .CW(4)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_hold              (hold),
        .i_flush             (flush),
        .i_stall             (stall),
        .i_id_pc4            (id.pc4),
        .i_id_read_data1     (id.rd1),
        .i_id_read_data2     (id.rd2),
        .i_id_sign_ext_imm   (id.imm),
        .i_id_reg_rs         (id.rs),
        .i_id_reg_rt         (id.rt),
        .i_id_reg_rd         (id.rd),
        .i_id_reg_write      (id.ctrl[8]),
        .i_id_memto_reg      (id.ctrl[7]),
        .i_id_mem_read       (id.ctrl[6]),
        .i_id_mem_write      (id.ctrl[5]),
        .i_id_branch         (id.ctrl[4]),
        .i_id_reg_dst        (id.ctrl[3]),
        .i_id_alu_src        (id.ctrl[2]),
        .i_id_alu_op         (id.ctrl[1:0]),
        .o_idex_pc4          (o_pc4),
        .o_idex_read_data1   (o_rd1),
        .o_idex_read_data2   (o_rd2),
        .o_idex_sign_ext_imm (o_imm),
        .o_idex_reg_rs       (o_rs),
        .o_idex_reg_rt       (o_rt),
        .o_idex_reg_rd       (o_rd),
        .o_idex_reg_write    (o_rw),
        .o_idex_memto_reg    (o_m2r),
        .o_idex_mem_read     (o_mr),
        .o_idex_mem_write    (o_mw),
        .o_idex_branch       (o_br),
        .o_idex_reg_dst      (o_rdst),
        .o_idex_alu_src      (o_asrc),
        .o_idex_alu_op       (o_aluop),
        .o_idex_valid        (o_valid),
        .o_bubble_count      (o_bc),
        .o_flush_count       (o_fc)
    );

    function automatic id_t rand_id();
        id_t r;
        r.pc4  = $urandom;
        r.rd1  = $urandom;
        r.rd2  = $urandom;
        r.imm  = $urandom;
        r.rs   = 5'($urandom);
        r.rt   = 5'($urandom);
        r.rd   = 5'($urandom);
        r.ctrl = 9'($urandom) | 9'h100;  // keep RegWrite set so bubbles are visible
        return r;
    endfunction

    // Drive one cycle of inputs and queue the hand-computed post-edge result.
    task automatic step(input logic r, input logic h, input logic f, input logic s,
                        input kind_e k, input int bc, input int fc);
        out_t e;
        rst_n = r;
        hold  = h;
        flush = f;
        stall = s;
        e = '0;
        case (k)
            KLoad: begin
                e.f     = id;
                e.valid = 1'b1;
            end
            KBubble: begin
                e.f      = id;
                e.f.ctrl = '0;
            end
            KHold: e = last_exp;
            default: e = '0;
        endcase
        if (k != KHold) begin
            e.bc = 4'(bc);
            e.fc = 4'(fc);
        end
        q_exp.push_back(e);
        q_tag.push_back(tag);
        last_exp = e;
        tag++;
        @(posedge clk);
        #2;
    endtask

    // Monitor: one registered result per clock edge.
    initial begin
        out_t e;
        int   t;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e   = q_exp.pop_front();
                t   = q_tag.pop_front();
                act = '{f: '{pc4: o_pc4, rd1: o_rd1, rd2: o_rd2, imm: o_imm, rs: o_rs,
                             rt: o_rt, rd: o_rd,
                             ctrl: {o_rw, o_m2r, o_mr, o_mw, o_br, o_rdst, o_asrc, o_aluop}},
                        valid: o_valid, bc: o_bc, fc: o_fc};
                n_chk++;
                if (act === e) n_pass++;
                else $display("FAIL step%0d: got %h required %h", t, act, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        id    = rand_id();
        #2;

        // Reset for two cycles with random ID inputs.
        step(1'b0, 1'b0, 1'b0, 1'b0, KZero, 0, 0);
        id = rand_id();
        step(1'b0, 1'b0, 1'b1, 1'b1, KZero, 0, 0);

        // lw $8: RegWrite, MemtoReg, MemRead, ALUSrc, ALUOp=00.
        id = '{pc4: 32'h0000_0104, rd1: 32'h1000_0000, rd2: 32'h0, imm: 32'h10,
               rs: 5'd29, rt: 5'd8, rd: 5'd0, ctrl: 9'b1_1100_0100};
        step(1'b1, 1'b0, 1'b0, 1'b0, KLoad, 0, 0);
        // add $9,$8,$1 in ID with load-use stall -> bubble.
        id = '{pc4: 32'h0000_0108, rd1: 32'h0000_00aa, rd2: 32'h0000_0011, imm: 32'h4820,
               rs: 5'd8, rt: 5'd1, rd: 5'd9, ctrl: 9'b1_0000_1010};
        step(1'b1, 1'b0, 1'b0, 1'b1, KBubble, 1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, KLoad, 1, 0);

        // Flush and Stall together: only FlushCount moves.
        id = rand_id();
        step(1'b1, 1'b0, 1'b1, 1'b1, KBubble, 1, 1);
        id = rand_id();
        step(1'b1, 1'b0, 1'b0, 1'b0, KLoad, 1, 1);

        // Hold for three cycles with Stall and changing inputs: frozen.
        for (int i = 0; i < 3; i++) begin
            id = rand_id();
            step(1'b1, 1'b1, (i == 1), 1'b1, KHold, 0, 0);
        end
        id = rand_id();
        step(1'b1, 1'b0, 1'b0, 1'b1, KBubble, 2, 1);

        // 20 consecutive stalls: BubbleCount saturates at 15.
        for (int i = 0; i < 20; i++) begin
            id = rand_id();
            step(1'b1, 1'b0, 1'b0, 1'b1, KBubble, (i < 13) ? 3 + i : 15, 1);
        end

        // Flushes up to FlushCount=7.
        for (int i = 0; i < 6; i++) begin
            id = rand_id();
            step(1'b1, 1'b0, 1'b1, 1'b0, KBubble, 15, 2 + i);
        end
        // Reset wins over a concurrent Flush.
        id = rand_id();
        step(1'b0, 1'b0, 1'b1, 1'b0, KZero, 0, 0);
        id = rand_id();
        step(1'b1, 1'b0, 1'b0, 1'b0, KLoad, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (q_exp.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending, required 0", q_exp.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
